// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer driving the f/p/wave words of a DDS core.
// Define DDS_SWEEP_BIDIR_EN to ping-pong between f_start and f_stop until stopped.
module dds_sweep_ctrl #(
   parameter int DWELL_W = 16
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [31:0]        cfg_f_start,
   input  logic [31:0]        cfg_f_stop,
   input  logic [31:0]        cfg_f_step,
   input  logic [DWELL_W-1:0] cfg_dwell,
   input  logic [14:0]        cfg_p_word,
   input  logic [1:0]         cfg_wave,
   input  logic               start,
   input  logic               stop,
   output logic [31:0]        f_word,
   output logic [14:0]        p_word,
   output logic [1:0]         wave_sel,
   output logic               upd,
   output logic               busy,
   output logic               done,
   output logic               err
);

   typedef enum logic [1:0] {IDLE, SWEEP_UP, SWEEP_DN, DONE} state_t;

   state_t             state_q, state_d;
   logic [31:0]        sh_start_q, sh_start_d, sh_stop_q, sh_stop_d, sh_step_q, sh_step_d;
   logic [DWELL_W-1:0] sh_dwell_q, sh_dwell_d, cnt_q, cnt_d;
   logic [14:0]        sh_p_q, sh_p_d, p_word_q, p_word_d;
   logic [1:0]         sh_wave_q, sh_wave_d, wave_q, wave_d;
   logic [31:0]        f_word_q, f_word_d;
   logic               upd_q, upd_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic               cfg_ready_q, cfg_ready_d;
   logic [32:0]        up_sum;
   logic [31:0]        up_next;
`ifdef DDS_SWEEP_BIDIR_EN
   logic [32:0]        dn_diff;
   logic [31:0]        dn_next;
`endif

   always_comb begin
      // 33-bit sum so a carry out of the top saturates to f_stop instead of wrapping
      up_sum  = {1'b0, f_word_q} + {1'b0, sh_step_q};
      up_next = (up_sum[32] || up_sum[31:0] >= sh_stop_q) ? sh_stop_q : up_sum[31:0];
`ifdef DDS_SWEEP_BIDIR_EN
      dn_diff = {1'b0, f_word_q} - {1'b0, sh_step_q};
      dn_next = (dn_diff[32] || dn_diff[31:0] <= sh_start_q) ? sh_start_q : dn_diff[31:0];
`endif

      state_d    = state_q;
      sh_start_d = sh_start_q;
      sh_stop_d  = sh_stop_q;
      sh_step_d  = sh_step_q;
      sh_dwell_d = sh_dwell_q;
      sh_p_d     = sh_p_q;
      sh_wave_d  = sh_wave_q;
      cnt_d      = cnt_q;
      f_word_d   = f_word_q;
      p_word_d   = p_word_q;
      wave_d     = wave_q;
      upd_d      = 1'b0;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = err_q;

      case (state_q)
         IDLE: begin
            if (cfg_valid) begin
               sh_start_d = cfg_f_start;
               sh_stop_d  = cfg_f_stop;
               sh_step_d  = cfg_f_step;
               sh_dwell_d = cfg_dwell;
               sh_p_d     = cfg_p_word;
               sh_wave_d  = cfg_wave;
            end
            if (start && !stop) begin
               if (sh_step_q == '0 || sh_start_q > sh_stop_q) begin
                  err_d = 1'b1;
               end else begin
                  state_d  = SWEEP_UP;
                  f_word_d = sh_start_q;
                  p_word_d = sh_p_q;
                  wave_d   = sh_wave_q;
                  cnt_d    = sh_dwell_q;
                  upd_d    = 1'b1;
                  busy_d   = 1'b1;
                  err_d    = 1'b0;
               end
            end
         end
         SWEEP_UP: begin
            if (stop) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - DWELL_W'(1);
            end else if (f_word_q == sh_stop_q) begin
`ifdef DDS_SWEEP_BIDIR_EN
               state_d  = SWEEP_DN;
               f_word_d = dn_next;
               upd_d    = (dn_next != f_word_q);
               cnt_d    = sh_dwell_q;
`else
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
`endif
            end else begin
               f_word_d = up_next;
               upd_d    = (up_next != f_word_q);
               cnt_d    = sh_dwell_q;
            end
         end
`ifdef DDS_SWEEP_BIDIR_EN
         SWEEP_DN: begin
            if (stop) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - DWELL_W'(1);
            end else if (f_word_q == sh_start_q) begin
               state_d  = SWEEP_UP;
               f_word_d = up_next;
               upd_d    = (up_next != f_word_q);
               cnt_d    = sh_dwell_q;
            end else begin
               f_word_d = dn_next;
               upd_d    = (dn_next != f_word_q);
               cnt_d    = sh_dwell_q;
            end
         end
`endif
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase

      cfg_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         sh_start_q  <= '0;
         sh_stop_q   <= '0;
         sh_step_q   <= '0;
         sh_dwell_q  <= '0;
         sh_p_q      <= '0;
         sh_wave_q   <= '0;
         cnt_q       <= '0;
         f_word_q    <= '0;
         p_word_q    <= '0;
         wave_q      <= '0;
         upd_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         cfg_ready_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         sh_start_q  <= sh_start_d;
         sh_stop_q   <= sh_stop_d;
         sh_step_q   <= sh_step_d;
         sh_dwell_q  <= sh_dwell_d;
         sh_p_q      <= sh_p_d;
         sh_wave_q   <= sh_wave_d;
         cnt_q       <= cnt_d;
         f_word_q    <= f_word_d;
         p_word_q    <= p_word_d;
         wave_q      <= wave_d;
         upd_q       <= upd_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         cfg_ready_q <= cfg_ready_d;
      end
   end

   assign cfg_ready = cfg_ready_q;
   assign f_word    = f_word_q;
   assign p_word    = p_word_q;
   assign wave_sel  = wave_q;
   assign upd       = upd_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: expected sweeps are built as word lists from the sweep rules.
// Build with DDS_SWEEP_BIDIR_EN to exercise the ping-pong variant.
module tb_dds_sweep_ctrl;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rstn;
   logic          cfg_valid, cfg_ready;
   logic [31:0]   cfg_f_start, cfg_f_stop, cfg_f_step;
   logic [DW-1:0] cfg_dwell;
   logic [14:0]   cfg_p_word;
   logic [1:0]    cfg_wave;
   logic          start, stop;
   logic [31:0]   f_word;
   logic [14:0]   p_word;
   logic [1:0]    wave_sel;
   logic          upd, busy, done, err;
   logic [53:0]   obs;

   int checks;
   int errors;

   dds_sweep_ctrl #(.DWELL_W(DW)) dut (
      .clk(clk), .rstn(rstn),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_f_start(cfg_f_start), .cfg_f_stop(cfg_f_stop), .cfg_f_step(cfg_f_step),
      .cfg_dwell(cfg_dwell), .cfg_p_word(cfg_p_word), .cfg_wave(cfg_wave),
      .start(start), .stop(stop),
      .f_word(f_word), .p_word(p_word), .wave_sel(wave_sel),
      .upd(upd), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // Observed bundle: {f_word, p_word, wave_sel, upd, busy, done, err, cfg_ready}
   assign obs = {f_word, p_word, wave_sel, upd, busy, done, err, cfg_ready};

   task automatic load_cfg(input logic [31:0] fs, input logic [31:0] fe, input logic [31:0] st,
                           input logic [DW-1:0] dw, input logic [14:0] pw, input logic [1:0] wv);
      cfg_f_start = fs; cfg_f_stop = fe; cfg_f_step = st;
      cfg_dwell = dw; cfg_p_word = pw; cfg_wave = wv;
      cfg_valid = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   task automatic test_reset;
      logic [53:0] exp;
      exp = {32'd0, 15'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL reset_held got %h exp %h", obs, exp);
      end
      rstn = 1'b1;
      @(negedge clk);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL reset_released got %h exp %h", obs, exp);
      end
   endtask

   // Run one complete upward sweep against a word list derived from start/stop/step.
   task automatic test_sweep(input string name, input logic [31:0] fs, input logic [31:0] fe,
                             input logic [31:0] st, input logic [DW-1:0] dw,
                             input logic [14:0] pw, input logic [1:0] wv, input bit hold_cfg);
      longint unsigned w, s;
      logic [31:0]     words[$];
      logic [53:0]     exp;
      int              hold, total;
      words.delete();
      w = fs;
      words.push_back(fs);
      while (w != fe && words.size() < 300) begin
         s = w + st;
         w = (s >= fe) ? fe : s;
         words.push_back(w[31:0]);
      end
      hold  = int'(dw) + 1;
      total = words.size() * hold;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (hold_cfg) cfg_valid = 1'b1;
      for (int t = 0; t < total; t++) begin
         exp = {words[t / hold], pw, wv, (t % hold) == 0, 1'b1, 1'b0, 1'b0, 1'b0};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got %h exp %h", name, t, obs, exp);
         end
         @(negedge clk);
      end
      exp = {fe, pw, wv, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s_done got %h exp %h", name, obs, exp);
      end
      @(negedge clk);
      exp = {fe, pw, wv, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s_idle got %h exp %h", name, obs, exp);
      end
   endtask

   task automatic test_error;
      logic [53:0] exp;
      load_cfg(32'd100, 32'd200, 32'd0, DW'(1), 15'h11, 2'd2);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      exp = {32'd0, 15'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL err_step0 got %h exp %h", obs, exp);
      end
      load_cfg(32'd300, 32'd200, 32'd5, DW'(1), 15'h11, 2'd2);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL err_order got %h exp %h", obs, exp);
      end
      load_cfg(32'd500, 32'd520, 32'd10, DW'(1), 15'h2ab, 2'd3);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      exp = {32'd500, 15'h2ab, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL err_cleared got %h exp %h", obs, exp);
      end
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      exp = {32'd500, 15'h2ab, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL err_stop got %h exp %h", obs, exp);
      end
   endtask

   task automatic test_abort;
      logic [53:0] exp;
      load_cfg(32'd0, 32'd1000, 32'd100, DW'(2), 15'h0f0, 2'd1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int t = 0; t < 6; t++) begin
         exp = {(t < 3) ? 32'd0 : 32'd100, 15'h0f0, 2'd1, (t % 3) == 0, 1'b1, 1'b0, 1'b0, 1'b0};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL abort_run t=%0d got %h exp %h", t, obs, exp);
         end
         if (t < 5) @(negedge clk);
      end
      // Dwell counter expires on this edge; stop must win
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      exp = {32'd100, 15'h0f0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int t = 0; t < 4; t++) begin
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL abort_hold t=%0d got %h exp %h", t, obs, exp);
         end
         @(negedge clk);
      end
   endtask

`ifndef DDS_SWEEP_BIDIR_EN
   task automatic test_cfg_handshake;
      load_cfg(32'd200, 32'd260, 32'd20, DW'(1), 15'h321, 2'd2);
      cfg_f_start = 32'd7; cfg_f_stop = 32'd9; cfg_f_step = 32'd1;
      cfg_dwell = DW'(0); cfg_p_word = 15'h456; cfg_wave = 2'd1;
      test_sweep("handshake_a", 32'd200, 32'd260, 32'd20, DW'(1), 15'h321, 2'd2, 1'b1);
      @(negedge clk);
      cfg_valid = 1'b0;
      checks++;
      if (cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL handshake_ready got %b exp 1", cfg_ready);
      end
      test_sweep("handshake_b", 32'd7, 32'd9, 32'd1, DW'(0), 15'h456, 2'd1, 1'b0);
   endtask

   task automatic test_random;
      for (int i = 0; i < 10; i++) begin
         longint unsigned fs, span, st;
         logic [DW-1:0]   dw;
         logic [14:0]     pw;
         logic [1:0]      wv;
         if (i % 3 == 2) fs = 64'hFFFF_FFFF - longint'($urandom_range(0, 400));
         else            fs = longint'($urandom_range(0, 32'h7FFF_FFFF));
         span = longint'($urandom_range(0, 400));
         if (fs + span > 64'hFFFF_FFFF) span = 64'hFFFF_FFFF - fs;
         st = longint'($urandom_range(1, 600));
         if (st < span / 12 + 1) st = span / 12 + 1;
         dw = DW'($urandom_range(0, 3));
         pw = 15'($urandom);
         wv = 2'($urandom);
         load_cfg(32'(fs), 32'(fs + span), 32'(st), dw, pw, wv);
         test_sweep("random", 32'(fs), 32'(fs + span), 32'(st), dw, pw, wv, 1'b0);
      end
   endtask
`else
   task automatic test_bidir;
      logic [31:0] seq [4];
      logic [53:0] exp;
      seq[0] = 32'd10; seq[1] = 32'd20; seq[2] = 32'd30; seq[3] = 32'd20;
      load_cfg(32'd10, 32'd30, 32'd10, DW'(0), 15'h77, 2'd3);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int t = 0; t < 12; t++) begin
         exp = {seq[t % 4], 15'h77, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL bidir t=%0d got %h exp %h", t, obs, exp);
         end
         if (t < 11) @(negedge clk);
      end
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      exp = {32'd20, 15'h77, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL bidir_stop got %h exp %h", obs, exp);
      end
   endtask
`endif

   task automatic test_reset_mid;
      logic [53:0] exp;
      load_cfg(32'd1000, 32'd2000, 32'd10, DW'(0), 15'h5, 2'd1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rstn = 1'b0;
      #1;
      exp = {32'd0, 15'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL midreset_async got %h exp %h", obs, exp);
      end
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL midreset_nodone got %h exp %h", obs, exp);
      end
      // Shadow registers are zero again, so step 0 makes this start invalid
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      exp = {32'd0, 15'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL midreset_shadow got %h exp %h", obs, exp);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rstn = 1'b0;
      cfg_valid = 1'b0;
      cfg_f_start = '0; cfg_f_stop = '0; cfg_f_step = '0;
      cfg_dwell = '0; cfg_p_word = '0; cfg_wave = '0;
      start = 1'b0;
      stop = 1'b0;
      repeat (2) @(negedge clk);
      test_reset;
      test_error;
`ifndef DDS_SWEEP_BIDIR_EN
      load_cfg(32'd100, 32'd130, 32'd10, DW'(2), 15'h1234, 2'd1);
      test_sweep("basic", 32'd100, 32'd130, 32'd10, DW'(2), 15'h1234, 2'd1, 1'b0);
      load_cfg(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, DW'(1), 15'h7fff, 2'd0);
      test_sweep("saturate", 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, DW'(1), 15'h7fff, 2'd0, 1'b0);
      load_cfg(32'd55, 32'd55, 32'd3, DW'(2), 15'h99, 2'd2);
      test_sweep("single", 32'd55, 32'd55, 32'd3, DW'(2), 15'h99, 2'd2, 1'b0);
      test_abort;
      test_cfg_handshake;
      test_random;
`else
      test_abort;
      test_bidir;
`endif
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Absolute time limit so a stuck run still reports
   initial begin
      #2000000;
      $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "time limit");
   end
endmodule

// File: doc/dds_sweep_ctrl.md
DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 SHALL have parameter DWELL_W, default 16, width of the dwell counter and of cfg_dwell.
REQ-002 SHALL have port clk, input, 1 bit, system clock; all logic on its rising edge.
REQ-003 SHALL have port rstn, input, 1 bit, reset; asynchronous, active-low.
REQ-004 SHALL have port cfg_valid, input, 1 bit, configuration-word valid.
REQ-005 SHALL have port cfg_ready, output, 1 bit, configuration can be accepted.
REQ-006 SHALL have ports cfg_f_start, cfg_f_stop and cfg_f_step, each input, 32 bits: start frequency word, stop frequency word, frequency increment.
REQ-007 SHALL have ports cfg_dwell (input, DWELL_W bits, hold cycles minus one), cfg_p_word (input, 15 bits, phase word) and cfg_wave (input, 2 bits, ROM waveform segment).
REQ-008 SHALL have ports start and stop, each input, 1 bit, single-cycle pulses: begin sweep and abort sweep.
REQ-009 SHALL have ports f_word (output, 32 bits) and p_word (output, 15 bits): frequency and phase words to the DDS core.
REQ-010 SHALL have port wave_sel, output, 2 bits, waveform segment select to the DDS core.
REQ-011 SHALL have port upd, output, 1 bit, one-cycle strobe when f_word, p_word or wave_sel changes.
REQ-012 SHALL have ports busy, done and err, each output, 1 bit: sweep active; one-cycle end-of-sweep pulse; sticky config error.

Function
REQ-013 SHALL implement the states IDLE, SWEEP_UP, SWEEP_DN and DONE; SWEEP_DN is reachable only under REQ-030.
REQ-014 SHALL drive cfg_ready high only in IDLE, and SHALL latch all cfg_* fields into shadow registers on a clock where cfg_valid and cfg_ready are both high.
REQ-015 SHALL ignore cfg_valid outside IDLE; the shadow registers SHALL remain unchanged.
REQ-016 SHALL validate start in IDLE: if cfg_f_step equals 0 or f_start is greater than f_stop, set err, stay in IDLE and leave the outputs unchanged.
REQ-017 SHALL, for a valid start sampled at edge N, enter SWEEP_UP; after edge N, f_word SHALL equal f_start, p_word and wave_sel SHALL be loaded from the shadow registers, upd SHALL be 1, busy SHALL be 1 and err SHALL be cleared.
REQ-018 SHALL hold each f_word value for exactly cfg_dwell+1 clocks, counted by a dwell counter that reloads on every f_word change.
REQ-019 SHALL, in SWEEP_UP on dwell expiry, set f_word to f_word+step; it SHALL set f_word to f_stop if that 33-bit sum carries or is greater than or equal to f_stop.
REQ-020 SHALL, when f_word reaches f_stop in SWEEP_UP, hold f_stop for one dwell period and then enter DONE.
REQ-021 SHALL, in DONE, pulse done for exactly one cycle, drop busy on the same cycle, return to IDLE, and hold f_word at f_stop.
REQ-022 SHALL assert upd for exactly one cycle on every f_word change, including a saturated step; it SHALL NOT assert upd when the value is unchanged.
REQ-023 SHALL, on a stop pulse in any non-IDLE state, return to IDLE next clock with busy 0 and done 0, holding f_word, p_word and wave_sel.
REQ-024 SHALL give stop priority over start and over dwell expiry when they arrive on the same clock.
REQ-025 SHALL ignore start while busy.
REQ-026 SHALL treat f_start equal to f_stop as a one-step sweep: load the word, dwell once, then DONE.

Reset
REQ-027 SHALL, while rstn is low, force IDLE, f_word 0, p_word 0, wave_sel 0, upd 0, busy 0, done 0, err 0, cfg_ready 1, shadow registers 0 and dwell counter 0.
REQ-028 SHALL abandon a sweep when reset is asserted mid-sweep, with no done pulse; the first valid start after release SHALL begin from the shadow register values, which are 0 until reloaded.

Configuration
REQ-029 SHALL, when macro DDS_SWEEP_BIDIR_EN is undefined, perform a single upward sweep as in REQ-019 to REQ-021.
REQ-030 SHALL, when DDS_SWEEP_BIDIR_EN is defined, enter SWEEP_DN instead of DONE on reaching f_stop; SWEEP_DN SHALL subtract step per dwell, floor at f_start, then re-enter SWEEP_UP, and SHALL loop until stop, never pulsing done.

Verification
REQ-031 SHALL cover a basic sweep: cfg start=100, stop=130, step=10, dwell=2, then start -> f_word 100/110/120/130, each held 3 clocks, 4 upd pulses, done 3 clocks after reaching 130.
REQ-032 SHALL cover saturation: start=0xFFFFFFF0, stop=0xFFFFFFFF, step=0x20 -> second word 0xFFFFFFFF with no wraparound, then done.
REQ-033 SHALL cover the error path: step=0 then start -> err=1, busy 0, no upd; a valid reconfig plus start then clears err.
REQ-034 SHALL cover abort: stop asserted together with a dwell expiry mid-sweep -> IDLE next clock, f_word unchanged, no upd, no done.
REQ-035 SHALL cover a config handshake: cfg_valid held while busy -> cfg_ready 0, shadow unchanged; after done, accepted in 1 clock.
REQ-036 SHALL cover bidirectional mode with DDS_SWEEP_BIDIR_EN defined: start=10, stop=30, step=10, dwell=0 -> f_word sequence 10,20,30,20,10,20,... until stop, done never high.
